// File: rtl/lut_sxx_pkg.sv
// Shared types and helpers for the scan-configured fracturable SXX LUT.
// CONFIG_PARITY_EN adds a trailing even-parity bit to every configuration frame.
package lut_sxx_pkg;

  typedef enum logic [1:0] {
    MODE_CASCADE = 2'b00,
    MODE_SPLIT   = 2'b01,
    MODE_SHARED  = 2'b10,
    MODE_WIDE    = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SHIFT  = 2'b01,
    ST_COMMIT = 2'b10
  } state_e;

`ifdef CONFIG_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Two truth tables, two mode bits, plus the optional parity bit.
  function automatic int frame_len(input int inputs, input bit parity);
    return 2 * (1 << inputs) + 2 + (parity ? 1 : 0);
  endfunction

endpackage

// File: rtl/lut_sxx_cfg_chain.sv
// Serial configuration chain: shadow shift register, bit counter, commit FSM.
// With CONFIG_PARITY_EN a frame failing even parity pulses err_o instead of committing.
module lut_sxx_cfg_chain
  import lut_sxx_pkg::*;
#(
  parameter  int INPUTS = 4,
  localparam int CFG_W  = 2 * (2 ** INPUTS) + 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             din_i,
  output logic             dout_o,
  output logic             done_o,
  output logic             valid_o,
`ifdef CONFIG_PARITY_EN
  output logic             err_o,
`endif
  output logic [CFG_W-1:0] cfg_o
);

  localparam int FRAME_LEN = frame_len(INPUTS, PARITY_EN);
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);

  logic [FRAME_LEN-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  state_e               state_q, state_d;
  logic [CFG_W-1:0]     cfg_q, cfg_d;
  logic                 done_q, done_d;
  logic                 valid_q, valid_d;
  logic                 frame_ok;
  logic [CFG_W-1:0]     frame_cfg;

  // The payload always sits at the top of the shadow register; parity, if any, is the LSB.
  assign frame_cfg = sr_q[FRAME_LEN-1 -: CFG_W];

`ifdef CONFIG_PARITY_EN
  logic err_q, err_d;
  assign frame_ok = ~(^sr_q);
  assign err_o    = err_q;
`else
  assign frame_ok = 1'b1;
`endif

  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    cfg_d   = cfg_q;
    done_d  = 1'b0;
    valid_d = valid_q;
`ifdef CONFIG_PARITY_EN
    err_d   = 1'b0;
`endif
    if (en_i) begin
      sr_d = {sr_q[FRAME_LEN-2:0], din_i};
    end
    case (state_q)
      ST_IDLE: begin
        if (en_i) begin
          cnt_d   = CNT_W'(1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (en_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
            state_d = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: begin
        // sr_q still holds the completed frame even if a new bit shifts in this cycle.
        if (frame_ok) begin
          cfg_d   = frame_cfg;
          done_d  = 1'b1;
          valid_d = 1'b1;
        end else begin
`ifdef CONFIG_PARITY_EN
          err_d = 1'b1;
`endif
        end
        cnt_d   = en_i ? CNT_W'(1) : CNT_W'(0);
        state_d = en_i ? ST_SHIFT : ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      state_q <= ST_IDLE;
      cfg_q   <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef CONFIG_PARITY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      cfg_q   <= cfg_d;
      done_q  <= done_d;
      valid_q <= valid_d;
`ifdef CONFIG_PARITY_EN
      err_q   <= err_d;
`endif
    end
  end

  assign dout_o  = sr_q[FRAME_LEN-1];
  assign done_o  = done_q;
  assign valid_o = valid_q;
  assign cfg_o   = cfg_q;

endmodule

// File: rtl/lut_sxx_scan_frac.sv
// Fracturable LUT pair (cascade/split/shared/wide) loaded through a serial scan chain.
// Build with CONFIG_PARITY_EN to require even parity per frame and expose config_err.
module lut_sxx_scan_frac
  import lut_sxx_pkg::*;
#(
  parameter  int INPUTS   = 4,
  localparam int MEM_SIZE = 2 ** INPUTS
) (
  input  logic                config_clk,
  input  logic                config_rst_n,
  input  logic                config_en,
  input  logic                config_in,
  output logic                config_out,
  output logic                config_done,
  output logic                config_valid,
`ifdef CONFIG_PARITY_EN
  output logic                config_err,
`endif
  input  logic [2*INPUTS-1:0] addr,
  output logic [1:0]          out
);

  localparam int CFG_W = 2 * MEM_SIZE + 2;

  logic [CFG_W-1:0]  cfg;
  mode_e             mode;
  logic              tbl_a [MEM_SIZE];
  logic              tbl_b [MEM_SIZE];
  logic [INPUTS-1:0] addr_a, addr_b;
  logic [INPUTS-1:0] a_idx, b_idx;
  logic              a_rd, b_rd;

  lut_sxx_cfg_chain #(
    .INPUTS (INPUTS)
  ) u_cfg_chain (
    .clk_i   (config_clk),
    .rst_ni  (config_rst_n),
    .en_i    (config_en),
    .din_i   (config_in),
    .dout_o  (config_out),
    .done_o  (config_done),
    .valid_o (config_valid),
`ifdef CONFIG_PARITY_EN
    .err_o   (config_err),
`endif
    .cfg_o   (cfg)
  );

  assign mode   = mode_e'(cfg[CFG_W-1 -: 2]);
  assign addr_a = addr[2*INPUTS-1:INPUTS];
  assign addr_b = addr[INPUTS-1:0];

  generate
    for (genvar gi = 0; gi < MEM_SIZE; gi++) begin : g_tbl
      assign tbl_a[gi] = cfg[MEM_SIZE + gi];
      assign tbl_b[gi] = cfg[gi];
    end
  endgenerate

  always_comb begin
    a_idx = addr_a;
    if (mode == MODE_SHARED || mode == MODE_WIDE) begin
      a_idx = addr_b;
    end
  end

  assign a_rd = tbl_a[a_idx];

  // Cascade feeds LUT_A's result into LUT_B's top address bit; split uses addr[K] there.
  always_comb begin
    b_idx = addr_b;
    case (mode)
      MODE_CASCADE: b_idx = {a_rd, addr_b[INPUTS-2:0]};
      MODE_SPLIT:   b_idx = {addr[INPUTS], addr_b[INPUTS-2:0]};
      default:      b_idx = addr_b;
    endcase
  end

  assign b_rd = tbl_b[b_idx];

  always_comb begin
    out = {a_rd, b_rd};
    if (mode == MODE_WIDE) begin
      out = {1'b0, (addr[INPUTS] ? a_rd : b_rd)};
    end
  end

endmodule

// File: tb/tb_lut_sxx_scan_frac.sv
// Scoreboard bench for lut_sxx_scan_frac with a behavioural frame/LUT model.
// Also covers the CONFIG_PARITY_EN build when that macro is defined.
module tb_lut_sxx_scan_frac;

  localparam int K  = 4;
  localparam int M  = 1 << K;
  localparam int CW = 2 * M + 2;
`ifdef CONFIG_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = CW + PAR;

  typedef struct {
    int            cyc;
    logic [CW-1:0] cfg;
    bit            ok;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         config_en = 1'b0;
  logic         config_in = 1'b0;
  logic         config_out, config_done, config_valid;
  logic [2*K-1:0] addr = '1;
  logic [1:0]   out;
`ifdef CONFIG_PARITY_EN
  logic         config_err;
`endif

  int vectors = 0;
  int miscompares = 0;

  int        cyc = 0;
  exp_t      exp_q[$];
  bit        hist[$];
  bit        fbits[$];
  logic [CW-1:0] act_cfg = '0;
  logic      act_valid = 1'b0;

  lut_sxx_scan_frac #(.INPUTS(K)) dut (
    .config_clk   (clk),
    .config_rst_n (rst_n),
    .config_en    (config_en),
    .config_in    (config_in),
    .config_out   (config_out),
    .config_done  (config_done),
    .config_valid (config_valid),
`ifdef CONFIG_PARITY_EN
    .config_err   (config_err),
`endif
    .addr         (addr),
    .out          (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [1:0] got, input logic [1:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, got, want);
    end
  endtask

  // Mode rules applied directly to the two truth tables.
  function automatic logic [1:0] ref_out(input logic [CW-1:0] c, input logic [2*K-1:0] a);
    int m, ai, bi, lo, hi;
    logic [M-1:0] ta, tb;
    logic o1, o0;
    m  = int'(c[CW-1 -: 2]);
    ta = c[2*M-1:M];
    tb = c[M-1:0];
    ai = int'(a[2*K-1:K]);
    bi = int'(a[K-1:0]);
    lo = bi % (M / 2);
    hi = int'(a[K]);
    case (m)
      0: begin o1 = ta[ai]; o0 = tb[(o1 ? M / 2 : 0) + lo]; end
      1: begin o1 = ta[ai]; o0 = tb[hi * (M / 2) + lo]; end
      2: begin o1 = ta[bi]; o0 = tb[bi]; end
      default: begin o1 = 1'b0; o0 = hi ? ta[bi] : tb[bi]; end
    endcase
    return {o1, o0};
  endfunction

  function automatic void model_clear();
    hist.delete();
    for (int i = 0; i < FL; i++) hist.push_back(1'b0);
    fbits.delete();
    exp_q.delete();
    act_cfg   = '0;
    act_valid = 1'b0;
  endfunction

  initial begin
    model_clear();
    forever begin
      @(negedge rst_n);
      model_clear();
    end
  end

  // Model: every enabled edge delivers one bit; the FL-th bit of a frame schedules a commit next edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst_n && config_en) begin
        logic [CW-1:0] c;
        bit p;
        hist.push_front(config_in);
        void'(hist.pop_back());
        fbits.push_back(config_in);
        if (fbits.size() == FL) begin
          c = '0;
          p = 1'b0;
          for (int i = 0; i < FL; i++) begin
            p ^= fbits[i];
            if (i < CW) c = {c[CW-2:0], fbits[i]};
          end
          exp_q.push_back('{cyc + 1, c, (PAR == 0) || (p == 1'b0)});
          fbits.delete();
        end
      end
    end
  end

  // Monitor: pops the scoreboard when a commit is due and checks every output each cycle.
  initial begin
    forever begin
      bit exp_done, exp_err;
      exp_t e;
      @(negedge clk);
      exp_done = 1'b0;
      exp_err  = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        if (e.ok) begin
          act_cfg   = e.cfg;
          act_valid = 1'b1;
          exp_done  = 1'b1;
        end else begin
          exp_err = 1'b1;
        end
      end
      check("config_done", {1'b0, config_done}, {1'b0, exp_done});
      check("config_valid", {1'b0, config_valid}, {1'b0, act_valid});
      check("config_out", {1'b0, config_out}, {1'b0, hist[FL-1]});
      check("out", out, ref_out(act_cfg, addr));
`ifdef CONFIG_PARITY_EN
      check("config_err", {1'b0, config_err}, {1'b0, exp_err});
`else
      if (exp_err) check("parity_unexpected", 2'b01, 2'b00);
`endif
    end
  end

  task automatic step(input bit en, input bit din, input logic [2*K-1:0] a);
    config_en = en;
    config_in = din;
    addr      = a;
    @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [1:0] mode, input logic [M-1:0] ta, input logic [M-1:0] tb,
                            input bit bad_par, input int gap_at, input int gap_len, input int nbits);
    logic [CW-1:0] payload;
    bit frame[$];
    payload = {mode, ta, tb};
    for (int i = CW - 1; i >= 0; i--) frame.push_back(payload[i]);
    if (PAR != 0) frame.push_back((^payload) ^ bad_par);
    for (int i = 0; i < nbits && i < FL; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) step(1'b0, 1'($urandom), 2*K'($urandom));
      end
      step(1'b1, frame[i], 2*K'($urandom));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), 2*K'($urandom));
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_out", out, 2'b00);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 8'hFF);
    step(1'b0, 1'b0, 8'hFF);

    send_frame(2'b01, 16'h8000, 16'h0001, 1'b0, -1, 0, FL);
    step(1'b0, 1'b0, 8'hF0);
    step(1'b0, 1'b0, 8'hF1);
    step(1'b0, 1'b0, 8'h01);
    step(1'b0, 1'b0, 8'h00);

    send_frame(2'b01, 16'h8000, 16'h0001, 1'b0, 10, 5, FL);
    idle(2);

    send_frame(2'b11, 16'hFFFF, 16'h0000, 1'b0, -1, 0, FL);
    step(1'b0, 1'b0, 8'h10);
    step(1'b0, 1'b0, 8'h00);

    // Back-to-back frames with no gap, random modes and tables.
    for (int f = 0; f < 4; f++)
      send_frame(2'($urandom), 16'($urandom), 16'($urandom), 1'b0, -1, 0, FL);
    idle(3);

    send_frame(2'b10, 16'hA5C3, 16'h3C5A, 1'b0, -1, 0, 20);
    rst_n = 1'b0;
    #1;
    check("rst_out", out, 2'b00);
    check("rst_done_valid", {config_done, config_valid}, 2'b00);
    check("rst_cout", {1'b0, config_out}, 2'b00);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    send_frame(2'b00, 16'($urandom), 16'($urandom), 1'b0, -1, 0, FL);
    idle(4);

`ifdef CONFIG_PARITY_EN
    send_frame(2'b01, 16'h1234, 16'h8765, 1'b1, -1, 0, FL);
    idle(3);
    send_frame(2'b01, 16'h1234, 16'h8765, 1'b0, -1, 0, FL);
    idle(3);
`endif

    for (int f = 0; f < 8; f++) begin
      send_frame(2'($urandom), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, FL + 5)), int'($urandom_range(0, 4)), FL);
      idle(int'($urandom_range(0, 3)));
    end
    idle(FL + 2);

    if (exp_q.size() != 0) check("pending_commits", 2'b01, 2'b00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
